// File: rtl/vga_timing_monitor.sv
// Receive-side VGA decoder: checks sync timing, locks after clean frames, recovers x/y and entity codes.
// Optional VGA_MON_MEASURE_EN adds o_meas_h_total / o_meas_v_total (measured line and frame periods).

`ifndef ENTITY_NOTHING
`define ENTITY_NOTHING 2'd0
`endif
`ifndef ENTITY_SNAKE
`define ENTITY_SNAKE 2'd1
`endif
`ifndef ENTITY_WALL
`define ENTITY_WALL 2'd2
`endif
`ifndef ENTITY_APPLE
`define ENTITY_APPLE 2'd3
`endif

module vga_timing_monitor #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_vga_hs,
  input  logic       i_vga_vs,
  input  logic [3:0] i_vga_r,
  input  logic [3:0] i_vga_g,
  input  logic [3:0] i_vga_b,
  output logic       o_locked,
  output logic       o_pixel_valid,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic [1:0] o_entity,
  output logic       o_entity_valid,
  output logic       o_color_err,
  output logic       o_h_err,
  output logic       o_v_err,
  output logic       o_frame_start,
  output logic [7:0] o_err_count
`ifdef VGA_MON_MEASURE_EN
  ,
  output logic [9:0] o_meas_h_total,
  output logic [9:0] o_meas_v_total
`endif
);

  localparam int unsigned CW      = 10;
  localparam int unsigned GW      = 4;
  localparam int unsigned EW      = 8;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_LIMIT = 2 * H_TOTAL;
  // h_pos must be able to reach the 2*H_TOTAL watchdog value
  localparam int unsigned HW      = ($clog2(H_LIMIT + 1) > CW) ? $clog2(H_LIMIT + 1) : CW;
  localparam int unsigned H_START = H_SYNC + H_BACK;
  localparam int unsigned H_END   = H_START + H_VISIBLE - 1;
  localparam int unsigned V_START = V_SYNC + V_BACK;
  localparam int unsigned V_END   = V_START + V_VISIBLE - 1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [GW-1:0] good_cnt, good_next;

  logic          hs_q, vs_line_q;
  logic          h_armed, v_armed;
  logic [HW-1:0] h_pos, h_pos_next, h_low;
  logic [CW-1:0] v_pos, v_pos_next, v_low;

  logic          hs_fall_c, hs_rise_c, vs_fall_c, vs_rise_c;
  logic          h_timeout_c, h_err_c, v_err_c, any_err_c;
  logic          visible_c, mapped_c, black_c;
  logic [1:0]    entity_c;
  logic [11:0]   rgb_c;

  // Sync edge detection and timing checks (suppressed while searching)
  always_comb begin
    hs_fall_c   = hs_q & ~i_vga_hs;
    hs_rise_c   = ~hs_q & i_vga_hs;
    vs_fall_c   = hs_fall_c & vs_line_q & ~i_vga_vs;
    vs_rise_c   = hs_fall_c & ~vs_line_q & i_vga_vs;
    h_timeout_c = ~hs_fall_c & (h_pos == HW'(H_LIMIT - 1));
    h_err_c     = 1'b0;
    v_err_c     = 1'b0;
    if (state != SEARCH) begin
      h_err_c = (hs_fall_c & h_armed & ((h_pos + HW'(1)) != HW'(H_TOTAL)))
              | (hs_rise_c & (h_low != HW'(H_SYNC)))
              | h_timeout_c;
      v_err_c = (vs_fall_c & v_armed & ((v_pos + CW'(1)) != CW'(V_TOTAL)))
              | (vs_rise_c & v_armed & (v_low != CW'(V_SYNC)));
    end
    any_err_c = h_err_c | v_err_c;
  end

  // Position of the pixel being sampled this cycle
  always_comb begin
    if (hs_fall_c) begin
      h_pos_next = '0;
    end else if (h_pos == HW'(H_LIMIT)) begin
      h_pos_next = h_pos;
    end else begin
      h_pos_next = h_pos + HW'(1);
    end
    v_pos_next = v_pos;
    if (vs_fall_c) begin
      v_pos_next = '0;
    end else if (hs_fall_c && (v_pos != '1)) begin
      v_pos_next = v_pos + CW'(1);
    end
    visible_c = (h_pos_next >= HW'(H_START)) && (h_pos_next <= HW'(H_END)) &&
                (v_pos_next >= CW'(V_START)) && (v_pos_next <= CW'(V_END));
  end

  // Colour to entity decode
  always_comb begin
    rgb_c    = {i_vga_r, i_vga_g, i_vga_b};
    entity_c = `ENTITY_NOTHING;
    mapped_c = 1'b1;
    black_c  = 1'b0;
    unique case (rgb_c)
      12'hFFF: entity_c = `ENTITY_NOTHING;
      12'h0F0: entity_c = `ENTITY_SNAKE;
      12'h00F: entity_c = `ENTITY_WALL;
      12'hF00: entity_c = `ENTITY_APPLE;
      12'h000: begin
        mapped_c = 1'b0;
        black_c  = 1'b1;
      end
      default: mapped_c = 1'b0;
    endcase
  end

  // Lock FSM: next state
  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    unique case (state)
      SEARCH: begin
        if (vs_fall_c) begin
          state_next = CHECK;
          good_next  = '0;
        end
      end
      CHECK: begin
        if (any_err_c) begin
          state_next = SEARCH;
          good_next  = '0;
        end else if (vs_fall_c) begin
          good_next = good_cnt + GW'(1);
          if ((good_cnt + GW'(1)) >= GW'(LOCK_FRAMES)) begin
            state_next = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (any_err_c) begin
          state_next = SEARCH;
          good_next  = '0;
        end
      end
      default: begin
        state_next = SEARCH;
        good_next  = '0;
      end
    endcase
    if (h_timeout_c) begin
      state_next = SEARCH;
      good_next  = '0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
    end
  end

  // Sync trackers: positions, sync-low widths, first-edge arming
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      hs_q      <= 1'b1;
      vs_line_q <= 1'b1;
      h_armed   <= 1'b0;
      v_armed   <= 1'b0;
      h_pos     <= '0;
      v_pos     <= '0;
      h_low     <= '0;
      v_low     <= '0;
    end else begin
      hs_q  <= i_vga_hs;
      h_pos <= h_pos_next;
      v_pos <= v_pos_next;
      if (hs_fall_c) begin
        vs_line_q <= i_vga_vs;
      end
      if (hs_fall_c) begin
        h_armed <= 1'b1;
      end else if (h_timeout_c) begin
        h_armed <= 1'b0;
      end
      if (vs_fall_c) begin
        v_armed <= 1'b1;
      end
      if (hs_fall_c) begin
        h_low <= HW'(1);
      end else if (!i_vga_hs && (h_low != '1)) begin
        h_low <= h_low + HW'(1);
      end
      if (vs_fall_c) begin
        v_low <= CW'(1);
      end else if (hs_fall_c && !i_vga_vs && (v_low != '1)) begin
        v_low <= v_low + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_locked       <= 1'b0;
      o_pixel_valid  <= 1'b0;
      o_x            <= '0;
      o_y            <= '0;
      o_entity       <= '0;
      o_entity_valid <= 1'b0;
      o_color_err    <= 1'b0;
      o_h_err        <= 1'b0;
      o_v_err        <= 1'b0;
      o_frame_start  <= 1'b0;
      o_err_count    <= '0;
    end else begin
      o_locked       <= (state_next == LOCKED);
      o_pixel_valid  <= visible_c;
      o_x            <= visible_c ? CW'(h_pos_next - HW'(H_START)) : '0;
      o_y            <= visible_c ? CW'(v_pos_next - CW'(V_START)) : '0;
      o_entity_valid <= visible_c & mapped_c;
      o_entity       <= (visible_c & mapped_c) ? entity_c : `ENTITY_NOTHING;
      o_color_err    <= visible_c & ~mapped_c & ~black_c & (state == LOCKED);
      o_h_err        <= h_err_c;
      o_v_err        <= v_err_c;
      o_frame_start  <= vs_fall_c;
      if (any_err_c && (o_err_count != '1)) begin
        o_err_count <= o_err_count + EW'(1);
      end
    end
  end

`ifdef VGA_MON_MEASURE_EN
  // Raw measured periods, including out-of-spec values
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_meas_h_total <= '0;
      o_meas_v_total <= '0;
    end else begin
      if (hs_fall_c) begin
        o_meas_h_total <= CW'(h_pos + HW'(1));
      end
      if (vs_fall_c) begin
        o_meas_v_total <= v_pos + CW'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a reduced 16x9 timing mode.
// Build with VGA_MON_MEASURE_EN to also check the measured-period outputs.

`ifndef ENTITY_NOTHING
`define ENTITY_NOTHING 2'd0
`endif
`ifndef ENTITY_SNAKE
`define ENTITY_SNAKE 2'd1
`endif
`ifndef ENTITY_WALL
`define ENTITY_WALL 2'd2
`endif
`ifndef ENTITY_APPLE
`define ENTITY_APPLE 2'd3
`endif

module tb_vga_timing_monitor;

  localparam int H_VISIBLE = 8;
  localparam int H_FRONT   = 2;
  localparam int H_SYNC    = 3;
  localparam int H_BACK    = 3;
  localparam int V_VISIBLE = 4;
  localparam int V_FRONT   = 1;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 2;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  logic       clock = 1'b0;
  logic       reset;
  logic       vga_hs, vga_vs;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       locked, pixel_valid, entity_valid, color_err, h_err, v_err, frame_start;
  logic [9:0] x, y;
  logic [1:0] entity;
  logic [7:0] err_count;
`ifdef VGA_MON_MEASURE_EN
  logic [9:0] meas_h, meas_v;
`endif

  always #5 clock = ~clock;

  vga_timing_monitor #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .LOCK_FRAMES(2)
  ) dut (
    .i_clock(clock), .i_reset(reset),
    .i_vga_hs(vga_hs), .i_vga_vs(vga_vs),
    .i_vga_r(vga_r), .i_vga_g(vga_g), .i_vga_b(vga_b),
    .o_locked(locked), .o_pixel_valid(pixel_valid), .o_x(x), .o_y(y),
    .o_entity(entity), .o_entity_valid(entity_valid), .o_color_err(color_err),
    .o_h_err(h_err), .o_v_err(v_err), .o_frame_start(frame_start),
    .o_err_count(err_count)
`ifdef VGA_MON_MEASURE_EN
    ,
    .o_meas_h_total(meas_h), .o_meas_v_total(meas_v)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int h_err_seen = 0, v_err_seen = 0, fs_seen = 0, cerr_seen = 0;

  always @(negedge clock) begin
    if (h_err) h_err_seen++;
    if (v_err) v_err_seen++;
    if (frame_start) fs_seen++;
    if (color_err) cerr_seen++;
  end

  int          paint_vc = -1;
  int          paint_hc = -1;
  logic [11:0] paint_rgb = 12'h000;
  logic        s_pv, s_ev, s_cerr, s_herr, s_verr, s_locked, s_fs;
  logic [9:0]  s_x, s_y, s_mh, s_mv;
  logic [1:0]  s_ent;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_line(input int vc, input logic vs, input int len, input int sync);
    for (int hc = 0; hc < len; hc++) begin
      vga_hs = (hc < sync) ? 1'b0 : 1'b1;
      vga_vs = vs;
      {vga_r, vga_g, vga_b} = (vc == paint_vc && hc == paint_hc) ? paint_rgb : 12'h000;
      tick();
      if (vc == paint_vc && hc == paint_hc) begin
        s_pv = pixel_valid; s_ev = entity_valid; s_cerr = color_err;
        s_herr = h_err; s_verr = v_err; s_locked = locked; s_fs = frame_start;
        s_x = x; s_y = y; s_ent = entity;
`ifdef VGA_MON_MEASURE_EN
        s_mh = meas_h; s_mv = meas_v;
`else
        s_mh = '0; s_mv = '0;
`endif
      end
    end
  endtask

  task automatic frame(input int n_lines, input int bad_vc, input int bad_len, input int bad_sync);
    for (int vc = 0; vc < n_lines; vc++) begin
      if (vc == bad_vc) drive_line(vc, (vc < V_SYNC) ? 1'b0 : 1'b1, bad_len, bad_sync);
      else              drive_line(vc, (vc < V_SYNC) ? 1'b0 : 1'b1, H_TOTAL, H_SYNC);
    end
  endtask

  task automatic good_frame();
    frame(V_TOTAL, -1, 0, 0);
  endtask

  task automatic paint(input int vc, input int hc, input logic [11:0] rgb);
    paint_vc = vc; paint_hc = hc; paint_rgb = rgb;
  endtask

  initial begin
    reset = 1'b1; vga_hs = 1'b1; vga_vs = 1'b1; {vga_r, vga_g, vga_b} = 12'h000;
    tick(); tick();
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_pixel_valid", 32'(pixel_valid), 0);
    chk("rst_x", 32'(x), 0);
    chk("rst_frame_start", 32'(frame_start), 0);

    // hs idle-high while searching: watchdog must stay silent
    reset = 1'b0;
    repeat (40) tick();
    chk("search_no_h_err", h_err_seen, 0);

    // Nominal lock: first vs fall enters CHECK, two clean frames lock
    good_frame(); good_frame();
    chk("not_locked_after_2", 32'(locked), 0);
    good_frame();
    chk("locked_after_3", 32'(locked), 1);
    chk("frame_start_count", fs_seen, 3);
    chk("nominal_h_err", h_err_seen, 0);
    chk("nominal_v_err", v_err_seen, 0);
    chk("nominal_err_count", 32'(err_count), 0);

    // Pixel decode at the visible corners and edges
    paint(4, 6, 12'h0F0); good_frame();
    chk("tl_valid", 32'(s_pv), 1); chk("tl_x", 32'(s_x), 0); chk("tl_y", 32'(s_y), 0);
    chk("tl_entity", 32'(s_ent), 32'(`ENTITY_SNAKE)); chk("tl_ev", 32'(s_ev), 1);
    paint(7, 13, 12'hF00); good_frame();
    chk("br_x", 32'(s_x), 7); chk("br_y", 32'(s_y), 3);
    chk("br_entity", 32'(s_ent), 32'(`ENTITY_APPLE)); chk("br_ev", 32'(s_ev), 1);
    paint(6, 10, 12'h00F); good_frame();
    chk("wall_entity", 32'(s_ent), 32'(`ENTITY_WALL)); chk("wall_x", 32'(s_x), 4); chk("wall_y", 32'(s_y), 2);
    paint(5, 9, 12'hFFF); good_frame();
    chk("white_ev", 32'(s_ev), 1); chk("white_entity", 32'(s_ent), 32'(`ENTITY_NOTHING));
    paint(4, 14, 12'h0F0); good_frame();
    chk("right_edge_pv", 32'(s_pv), 0); chk("right_edge_x", 32'(s_x), 0); chk("right_edge_ev", 32'(s_ev), 0);
    paint(3, 6, 12'h0F0); good_frame();
    chk("top_edge_pv", 32'(s_pv), 0);
    paint(5, 8, 12'h888); good_frame();
    chk("bad_col_pv", 32'(s_pv), 1); chk("bad_col_ev", 32'(s_ev), 0);
    chk("bad_col_entity", 32'(s_ent), 32'(`ENTITY_NOTHING)); chk("bad_col_err", 32'(s_cerr), 1);
    chk("bad_col_x", 32'(s_x), 2);
    chk("color_err_count", cerr_seen, 1);
    chk("color_no_timing_err", 32'(err_count), 0);
    chk("color_still_locked", 32'(locked), 1);

    // One 17-clock line while locked
    paint(4, 0, 12'h000); frame(V_TOTAL, 3, H_TOTAL + 1, H_SYNC);
    chk("long_line_h_err", 32'(s_herr), 1); chk("long_line_unlock", 32'(s_locked), 0);
    chk("long_line_v_err", 32'(s_verr), 0);
`ifdef VGA_MON_MEASURE_EN
    chk("meas_h_total", 32'(s_mh), H_TOTAL + 1);
`endif
    chk("long_line_pulses", h_err_seen, 1);
    chk("long_line_count", 32'(err_count), 1);
    paint(-1, -1, 12'h000);
    good_frame(); good_frame();
    chk("relock_not_yet", 32'(locked), 0);
    good_frame();
    chk("relock", 32'(locked), 1);

    // 8-line frame while locked: flagged at the following vs fall
    frame(V_TOTAL - 1, -1, 0, 0);
    paint(0, 0, 12'h000); good_frame();
    chk("short_frame_v_err", 32'(s_verr), 1); chk("short_frame_unlock", 32'(s_locked), 0);
    chk("short_frame_fs", 32'(s_fs), 1);
`ifdef VGA_MON_MEASURE_EN
    chk("meas_v_total", 32'(s_mv), V_TOTAL - 1);
`endif
    chk("short_frame_count", 32'(err_count), 2);

    // hs stuck high in CHECK: watchdog at h_pos == 2*H_TOTAL
    paint(-1, -1, 12'h000); good_frame();
    paint(3, 16, 12'h000); frame(V_TOTAL, 3, 40, 0);
    chk("timeout_h_err", 32'(s_herr), 1); chk("timeout_locked", 32'(s_locked), 0);
    chk("timeout_count", 32'(err_count), 3);

    // Short-line/short-vsync pairs: h and v errors coincide, counted once
    paint(1, 0, 12'h000);
    drive_line(0, 1'b0, H_TOTAL - 1, H_SYNC); drive_line(1, 1'b1, H_TOTAL, H_SYNC);
    chk("coincide_h", 32'(s_herr), 1); chk("coincide_v", 32'(s_verr), 1);
    chk("coincide_count", 32'(err_count), 4);
    paint(-1, -1, 12'h000);
    repeat (250) begin
      drive_line(0, 1'b0, H_TOTAL - 1, H_SYNC); drive_line(1, 1'b1, H_TOTAL, H_SYNC);
    end
    chk("count_254", 32'(err_count), 254);
    repeat (9) begin
      drive_line(0, 1'b0, H_TOTAL - 1, H_SYNC); drive_line(1, 1'b1, H_TOTAL, H_SYNC);
    end
    chk("count_saturated", 32'(err_count), 255);

    // Relock, then reset in the middle of a visible line
    good_frame(); good_frame(); good_frame();
    chk("pre_reset_locked", 32'(locked), 1);
    frame(5, -1, 0, 0);
    drive_line(5, 1'b1, 8, H_SYNC);
    chk("pre_reset_pv", 32'(pixel_valid), 1);
    chk("pre_reset_y", 32'(y), 1);
    reset = 1'b1;
    #1;
    chk("mid_reset_locked", 32'(locked), 0);
    chk("mid_reset_pv", 32'(pixel_valid), 0);
    chk("mid_reset_y", 32'(y), 0);
    chk("mid_reset_count", 32'(err_count), 0);
    tick();
    reset = 1'b0;
    good_frame(); good_frame();
    chk("post_reset_not_locked", 32'(locked), 0);
    good_frame();
    chk("post_reset_relock", 32'(locked), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_monitor.md
Name: vga_timing_monitor

Overview:
- Receive-side decoder for the game's VGA output. Samples hs/vs/RGB on the pixel clock, checks sync timing against the expected mode, and locks after consecutive good frames.
- Recovers pixel coordinates and decodes pixel colour back to an entity code.
- Used in simulation and on-board self-check, wired directly to the display controller's VGA outputs.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, h front porch clocks
H_SYNC, 96, h sync low clocks
H_BACK, 48, h back porch clocks
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, v front porch lines
V_SYNC, 2, v sync low lines
V_BACK, 33, v back porch lines
LOCK_FRAMES, 2, consecutive error-free frames required to lock (1..15)

Ports:
i_clock  in  1  pixel clock
i_reset  in  1  async active-high reset
i_vga_hs  in  1  h sync, active low
i_vga_vs  in  1  v sync, active low
i_vga_r  in  4  red
i_vga_g  in  4  green
i_vga_b  in  4  blue
o_locked  out  1  timing locked
o_pixel_valid  out  1  o_x/o_y/o_entity describe a visible pixel
o_x  out  10  recovered column
o_y  out  10  recovered row
o_entity  out  2  decoded entity (`ENTITY_* codes from define.svh)
o_entity_valid  out  1  colour mapped to an entity
o_color_err  out  1  one-cycle pulse: visible pixel with unmapped colour (locked only)
o_h_err  out  1  one-cycle pulse: horizontal timing violation
o_v_err  out  1  one-cycle pulse: vertical timing violation
o_frame_start  out  1  one-cycle pulse on each vs falling edge
o_err_count  out  8  saturating timing-error count

Behaviour:
- Reset: all outputs 0; internal hs_q/vs_q = 1; FSM = SEARCH; counters 0. Interface clock is i_clock, reset is i_reset, asynchronous, active-high.
- H_TOTAL = sum of H_*; V_TOTAL = sum of V_*. Counters are 10 bit.
- hs fall: hs_q==1 && i_vga_hs==0. On that cycle h_pos <= 0; otherwise h_pos increments.
- h_period counts clocks between falls. Flag h_err at a fall if h_period+1 != H_TOTAL (skipped on the first fall after SEARCH).
- hs rise: h_err if the low width != H_SYNC.
- h_pos reaching 2*H_TOTAL without a fall: h_err, FSM -> SEARCH, h_pos holds.
- vs is sampled only at hs fall (vs_line_q holds the previous sample).
  - vs fall (vs_line_q==1, vs==0): v_pos <= 0, o_frame_start pulse. v_err if lines since the previous vs fall != V_TOTAL (skipped on the first fall).
  - Other hs falls: v_pos increments.
  - At the vs rise, v_err if the low length != V_SYNC lines.
- Visible region:
  - h_pos in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VISIBLE-1] and v_pos in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VISIBLE-1].
  - o_x = h_pos-(H_SYNC+H_BACK); o_y = v_pos-(V_SYNC+V_BACK).
  - Outside the visible region o_pixel_valid=0 and o_x/o_y hold 0.
- Latency: o_x/o_y/o_entity/o_pixel_valid are registered, 1 clock after the RGB sample they describe.
- Colour decode:
  - F/F/F -> NOTHING; 0/F/0 -> SNAKE; 0/0/F -> WALL; F/0/0 -> APPLE; o_entity_valid=1.
  - 0/0/0 -> o_entity_valid=0, no error (blanked pixel).
  - Any other colour -> o_entity_valid=0, with o_color_err pulsed if o_locked.
  - When o_entity_valid=0, o_entity = `ENTITY_NOTHING.
- FSM:
  - SEARCH: o_locked=0, error checks suppressed. First vs fall -> CHECK, good-frame counter = 0.
  - CHECK: any h_err/v_err -> SEARCH. Each error-free vs fall increments the good-frame counter; reaching LOCK_FRAMES -> LOCKED.
  - LOCKED: o_locked=1. Any h_err/v_err -> SEARCH, with o_locked cleared the next cycle.
- o_h_err/o_v_err pulse in CHECK and LOCKED. o_err_count increments by exactly 1 per cycle with any error, even when h and v errors coincide, and saturates at 255. It clears only on reset.
- Reset mid-frame: immediate return to reset state; relock requires a full new sequence.

Optional Feature:
VGA_MON_MEASURE_EN:
- Defined: adds outputs o_meas_h_total[9:0] and o_meas_v_total[9:0] (reset 0). They are updated with the measured clocks per line at every hs fall and lines per frame at every vs fall, including mismatching values, so benches can read the faulty period.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Nominal 640x480 stimulus, 3 frames -> o_locked rises after 2nd vs fall post-SEARCH; no o_h_err/o_v_err; o_err_count=0; o_frame_start once per 525 lines.
- Locked; pixel at h_pos=144, v_pos=35 driven 0/F/0 -> one clock later o_pixel_valid=1, o_x=0, o_y=0, o_entity=SNAKE; pixel at o_x=639, o_y=479 driven F/0/0 -> APPLE.
- Locked; one line with 801 clocks -> single o_h_err pulse, o_locked=0 next cycle, o_err_count=1, relock after 2 clean frames.
- Locked; colour 8/8/8 at o_x=10 -> o_color_err one pulse, o_entity_valid=0, o_err_count unchanged.
- hs held high 1600 clocks while in CHECK -> o_h_err, FSM SEARCH; 256 induced errors -> o_err_count saturates at 255.
- i_reset asserted mid-frame while locked -> all outputs 0 same cycle; with VGA_MON_MEASURE_EN a 524-line frame shows o_meas_v_total=524.
